// File: rtl/fp_pkg_amisha.sv
// Shared defaults and FSM state encoding for the float-to-integer converter.
package fp_pkg_amisha;

    localparam int DEF_EXP_W       = 4;
    localparam int DEF_FRAC_W      = 8;
    localparam int DEF_INT_W       = 16;
    localparam int DEF_SHIFT_CNT_W = DEF_EXP_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/fp_int_finish_amisha.sv
// Final stage of the float-to-integer converter: optional round, then signed negate.
// FP2INT_ROUND_EN adds the last shifted-out bit to the magnitude (round half away from zero).
module fp_int_finish_amisha #(
    parameter int INT_W = 16
) (
    input  logic [INT_W-1:0] mag,
    input  logic             sign,
`ifdef FP2INT_ROUND_EN
    input  logic             guard,
`endif
    output logic [INT_W-1:0] value
);

    logic [INT_W-1:0] rounded;

    always_comb begin
`ifdef FP2INT_ROUND_EN
        rounded = mag + INT_W'(guard);
`else
        rounded = mag;
`endif
        // Negating a zero magnitude yields zero, so negative zero cannot appear.
        value = sign ? ('0 - rounded) : rounded;
    end

endmodule

// File: rtl/fp_to_int_amisha.sv
// Multi-cycle sign/exponent/fraction float to two's-complement integer converter.
// A bit-serial shifter is stepped by an FSM; define FP2INT_ROUND_EN to round instead of truncate.
module fp_to_int_amisha
    import fp_pkg_amisha::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int INT_W  = DEF_INT_W
) (
    input  logic              clk_amisha,
    input  logic              rst_n_amisha,
    input  logic              in_valid_amisha,
    output logic              in_ready_amisha,
    input  logic              sign_amisha,
    input  logic [EXP_W-1:0]  exp_amisha,
    input  logic [FRAC_W-1:0] frac_amisha,
    output logic              out_valid_amisha,
    input  logic              out_ready_amisha,
    output logic [INT_W-1:0]  int_out_amisha
);

    localparam int CNT_W = EXP_W + 1;
    localparam logic [CNT_W-1:0] FRAC_W_C = CNT_W'(FRAC_W);

    state_t            state;
    state_t            state_next;
    logic [INT_W-1:0]  mag;
    logic [INT_W-1:0]  int_q;
    logic [INT_W-1:0]  fin_value;
    logic              sign_q;
    logic              shift_left;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  exp_ext;
    logic [CNT_W-1:0]  cnt_init;
    logic              left_init;
    logic              accept;
`ifdef FP2INT_ROUND_EN
    logic              guard;
`endif

    always_comb begin
        exp_ext   = {1'b0, exp_amisha};
        left_init = (exp_ext >= FRAC_W_C);
        cnt_init  = left_init ? (exp_ext - FRAC_W_C) : (FRAC_W_C - exp_ext);
        accept    = in_valid_amisha && (state == IDLE);
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (cnt_init != '0) ? SHIFT : FINISH;
            // cnt reaches zero on the edge that performs the last shift
            SHIFT:   if (cnt == CNT_W'(1)) state_next = FINISH;
            FINISH:  state_next = HOLD;
            HOLD:    if (out_ready_amisha) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_amisha  = (state == IDLE);
        out_valid_amisha = (state == HOLD);
        int_out_amisha   = int_q;
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            mag        <= '0;
            sign_q     <= 1'b0;
            shift_left <= 1'b0;
            cnt        <= '0;
            int_q      <= '0;
`ifdef FP2INT_ROUND_EN
            guard      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag        <= INT_W'(frac_amisha);
                        sign_q     <= sign_amisha;
                        shift_left <= left_init;
                        cnt        <= cnt_init;
`ifdef FP2INT_ROUND_EN
                        guard      <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (shift_left) begin
                        mag <= mag << 1;
                    end else begin
                        mag <= mag >> 1;
`ifdef FP2INT_ROUND_EN
                        guard <= mag[0];
`endif
                    end
                end
                FINISH: int_q <= fin_value;
                default: ;
            endcase
        end
    end

    fp_int_finish_amisha #(
        .INT_W (INT_W)
    ) u_finish (
        .mag   (mag),
        .sign  (sign_q),
`ifdef FP2INT_ROUND_EN
        .guard (guard),
`endif
        .value (fin_value)
    );

endmodule

// File: tb/tb_fp_to_int_amisha.sv
// Randomized self-checking bench for fp_to_int_amisha against an arithmetic reference model.
// Honours FP2INT_ROUND_EN when the same macro is defined for the bench build.
module tb_fp_to_int_amisha;

`ifdef FP2INT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [3:0]  exp;
    logic [7:0]  frac;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] int_out;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    fp_to_int_amisha #(
        .EXP_W  (4),
        .FRAC_W (8),
        .INT_W  (16)
    ) dut (
        .clk_amisha       (clk),
        .rst_n_amisha     (rst_n),
        .in_valid_amisha  (in_valid),
        .in_ready_amisha  (in_ready),
        .sign_amisha      (sign),
        .exp_amisha       (exp),
        .frac_amisha      (frac),
        .out_valid_amisha (out_valid),
        .out_ready_amisha (out_ready),
        .int_out_amisha   (int_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    // value = frac/256 * 2^exp; integer part, optionally bumped by the first bit below the point
    function automatic logic [15:0] ref_convert(input logic s, input logic [3:0] e, input logic [7:0] f);
        logic [31:0] scaled;
        logic [31:0] m;
        scaled = {24'd0, f} << e;
        m      = scaled >> 8;
        if (ROUND) m = m + {31'd0, scaled[7]};
        return s ? (16'd0 - m[15:0]) : m[15:0];
    endfunction

    function automatic int unsigned ref_latency(input logic [3:0] e);
        int unsigned d;
        d = (e >= 4'd8) ? (int'(e) - 8) : (8 - int'(e));
        return d + 2;  // edges counted with the accepting edge as edge 1
    endfunction

    task automatic run_op(input logic s, input logic [3:0] e, input logic [7:0] f,
                          input int unsigned hold, input bit poke);
        logic [15:0] want;
        int unsigned lat;
        bit          stray;
        want      = ref_convert(s, e, f);
        out_ready = (hold == 0);
        check_eq("ready_before_op", {31'd0, in_ready}, 32'd1);
        sign = s; exp = e; frac = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("out_valid_seen", {31'd0, out_valid}, 32'd1);
        check_eq("latency", lat, ref_latency(e));
        check_eq("result", {16'd0, int_out}, {16'd0, want});
        check_eq("busy_ready", {31'd0, in_ready}, 32'd0);
        for (int unsigned i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1; sign = ~s; exp = e ^ 4'h5; frac = f ^ 8'hA5;
            end
            @(posedge clk); #1;
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_stable", {16'd0, int_out}, {16'd0, want});
            check_eq("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("handoff_clear", {31'd0, out_valid}, 32'd0);
        check_eq("handoff_idle", {31'd0, in_ready}, 32'd1);
        check_eq("result_kept", {16'd0, int_out}, {16'd0, want});
        if (poke) begin
            stray = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (out_valid || !in_ready) stray = 1'b1;
            end
            check_eq("poke_ignored", {31'd0, stray}, 32'd0);
        end
    endtask

    initial begin
        bit stale;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sign = 1'b0; exp = '0; frac = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ready", {31'd0, in_ready}, 32'd1);
        check_eq("reset_valid", {31'd0, out_valid}, 32'd0);
        check_eq("reset_int", {16'd0, int_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 4'd12, 8'd52, 0, 1'b0);
        check_eq("const_832", {16'd0, int_out}, 32'h0340);
        run_op(1'b1, 4'd8, 8'd25, 0, 1'b0);
        check_eq("const_m25", {16'd0, int_out}, 32'hFFE7);
        run_op(1'b1, 4'd3, 8'd32, 0, 1'b0);
        run_op(1'b0, 4'd5, 8'd12, 0, 1'b0);
        check_eq("one_point_five", {16'd0, int_out}, ROUND ? 32'd2 : 32'd1);
        run_op(1'b0, 4'd0, 8'h80, 0, 1'b0);
        run_op(1'b1, 4'd9, 8'd0, 0, 1'b0);
        check_eq("neg_zero", {16'd0, int_out}, 32'd0);
        run_op(1'b0, 4'd15, 8'd255, 5, 1'b1);
        check_eq("max_mag", {16'd0, int_out}, 32'h7F80);

        // Reset while shifting must drop the operation entirely
        out_ready = 1'b1;
        sign = 1'b1; exp = 4'd14; frac = 8'h80; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midop_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midop_ready", {31'd0, in_ready}, 32'd1);
        check_eq("midop_int", {16'd0, int_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid || int_out != 16'd0) stale = 1'b1;
        end
        check_eq("no_stale_result", {31'd0, stale}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
